mem_io_responder: RTL
=====================

// Module: mem_io_responder
// PURPOSE
//  Responder end of the CPU byte-wide memory bus (mem_a/mem_wr/mem_dout/mem_din/io_buffer_full).
//  Serves 128KB RAM with 1-cycle read latency, decodes the I/O window (mem_a[17:16]==2'b11),
//  and buffers UART TX/RX bytes in FIFOs. It also exposes the cycle counter and the program-stop flag.
//  Sits between the cpu top and the UART/board wrapper; replaces the ad-hoc RAM+IO glue.
// PARAMETERS
//  ADDR_WIDTH   17  RAM byte-address bits (2^17 = 128KB)
//  TX_DEPTH     16  TX FIFO entries (power of 2)
//  RX_DEPTH     16  RX FIFO entries (power of 2)
//  FULL_MARGIN  2   io_buffer_full asserts when TX free slots <= FULL_MARGIN
// PORTS
//  clk_in          in   1   single clock; all state on rising edge
//  rst_in          in   1   reset, asynchronous, active-high
//  mem_a           in   32  CPU address (bits 17:0 used)
//  mem_wr          in   1   1 = write, 0 = read (every cycle with mem_wr=0 is a read)
//  mem_dout        in   8   CPU write data
//  mem_din         out  8   read data, valid the cycle after the read
//  io_buffer_full  out  1   TX FIFO nearly full; CPU must not write 0x30000
//  tx_data         out  8   byte to UART transmitter
//  tx_valid        out  1   TX FIFO non-empty
//  tx_ready        in   1   UART accepts tx_data this cycle
//  rx_data         in   8   byte from UART receiver
//  rx_valid        in   1   rx_data present
//  rx_ready        out  1   RX FIFO not full
//  program_stop    out  1   sticky; set by write to 0x30004
//  tx_overflow     out  1   sticky; set when a TX push is dropped because the FIFO is full
// BEHAVIOUR
//  Reset: mem_din=0, FIFOs empty (tx_valid=0, rx_ready=1), io_buffer_full=0, program_stop=0,
//    tx_overflow=0, cycle counter=0, snapshot=0. RAM contents are not reset.
//  Decode: io = (mem_a[17:16]==2'b11). RAM index = mem_a[ADDR_WIDTH-1:0].
//  RAM write: a byte is written at the edge where mem_wr=1 and !io.
//  RAM read: mem_din <= ram[index] at the next edge, giving 1-cycle latency.
//  Only one access occurs per cycle, so there is no read/write hazard.
//  IO write 0x30000: if mem_dout==0, ignored. Otherwise, push to TX when count<TX_DEPTH.
//    If the FIFO is full, the byte is dropped and tx_overflow is set.
//    A same-cycle pop does not make room for the push.
//  IO write 0x30004: push 0x00 to TX (subject to the same full rule) and set program_stop.
//    While program_stop=1, all IO writes are ignored.
//  IO read 0x30000: if RX is non-empty, mem_din <= RX head and the head is popped at that edge.
//    If RX is empty, mem_din <= 0x00.
//  IO read 0x30004+k (k=mem_a[1:0]): mem_din <= snapshot byte k (little-endian).
//    A read with k=0 also loads snapshot <= cycle counter at that edge.
//    The byte returned for k=0 is the new counter value, so 4 sequential byte reads are coherent.
//  Other IO addresses: reads return 0x00; writes are ignored.
//  Cycle counter: 32-bit, +1 every cycle after reset, wraps 0xFFFFFFFF->0, never stops.
//  TX FIFO: pops when tx_valid&tx_ready. io_buffer_full = (TX_DEPTH - count) <= FULL_MARGIN,
//    registered from the next-count value so it is valid the cycle after a push or pop.
//  RX FIFO: pushes when rx_valid&rx_ready. A push and a pop in the same cycle are both honoured
//    when 0<count<RX_DEPTH. On a push to an empty FIFO, the byte is readable from the next cycle.
//  Pointers are log2(DEPTH) bits plus a count register (0..DEPTH); wrap is natural modulo DEPTH.
//  Asserting rst_in mid-operation clears all FIFOs and flags immediately; any in-flight read is lost.
// TESTING
//  1. Write 0xA5 to 0x00010, then read 0x00010 -> mem_din=0xA5 one cycle after the read; 0x1FFFF round-trips.
//  2. Write 0x41,0x00,0x42 to 0x30000 with tx_ready=0 -> TX count=2; raising tx_ready gives tx_data 0x41 then 0x42.
//  3. Write 16 non-zero bytes with tx_ready=0 -> io_buffer_full=1 once count>=14;
//     the 17th write is dropped and tx_overflow=1.
//  4. Drive rx 0x31,0x32; read 0x30000 x3 -> mem_din 0x31, 0x32, 0x00.
//     With the RX FIFO full, rx_ready=0 and further rx bytes are not taken.
//  5. Read 0x30004..0x30007 at cycle 1000 -> counter snapshot bytes are coherent even though the counter advances.
//     Preload 0xFFFFFFFE -> the counter wraps to 0.
//  6. Write 0x30004 -> program_stop=1 and 0x00 is queued to TX; a later 0x30000 write is ignored.
//     Asserting rst_in mid-stream clears everything.

Source files
------------

// File: rtl/mem_io_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_responder_if
// Brief    : CPU byte bus plus UART TX/RX byte streams served by mem_io_responder.
// Revision : 1.0
// ============================================================================
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_stop;
    logic        tx_overflow;

    // master: CPU and UART side driving the responder
    modport master (
        output mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
        input  mem_din, io_buffer_full, tx_data, tx_valid, rx_ready, program_stop, tx_overflow
    );

    modport slave (
        input  mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
        output mem_din, io_buffer_full, tx_data, tx_valid, rx_ready, program_stop, tx_overflow
    );
endinterface
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_responder
// Brief    : RAM, I/O window decode, UART TX/RX FIFOs, cycle counter snapshot
//            and program-stop flag behind the CPU byte-wide memory bus.
// Revision : 1.0
// ============================================================================
module mem_io_responder #(
    parameter int          ADDR_WIDTH  = 17,
    parameter int          TX_DEPTH    = 16,
    parameter int          RX_DEPTH    = 16,
    parameter int          FULL_MARGIN = 2,
    parameter logic [31:0] CYCLE_RESET = 32'h0000_0000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    mem_io_responder_if.slave bus
);

    localparam int c_tx_aw = $clog2(TX_DEPTH);
    localparam int c_tx_cw = c_tx_aw + 1;
    localparam int c_rx_aw = $clog2(RX_DEPTH);
    localparam int c_rx_cw = c_rx_aw + 1;

    localparam logic [c_tx_cw-1:0] c_tx_full    = c_tx_cw'(TX_DEPTH);
    localparam logic [c_tx_cw-1:0] c_tx_margin  = c_tx_cw'(FULL_MARGIN);
    localparam logic [c_tx_cw-1:0] c_tx_cnt_one = c_tx_cw'(1);
    localparam logic [c_tx_aw-1:0] c_tx_ptr_one = c_tx_aw'(1);
    localparam logic [c_rx_cw-1:0] c_rx_full    = c_rx_cw'(RX_DEPTH);
    localparam logic [c_rx_cw-1:0] c_rx_cnt_one = c_rx_cw'(1);
    localparam logic [c_rx_aw-1:0] c_rx_ptr_one = c_rx_aw'(1);

    localparam logic [17:0] c_addr_uart = 18'h3_0000;
    localparam logic [17:0] c_addr_stop = 18'h3_0004;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [17:0]           w_addr;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic                  w_io;
    logic                  w_io_wr;
    logic                  w_io_rd;
    logic                  w_sel_uart;
    logic                  w_sel_stop;
    logic                  w_sel_cnt;
    logic                  w_unused_addr;

    assign w_addr        = bus.mem_a[17:0];
    assign w_ram_idx     = bus.mem_a[ADDR_WIDTH-1:0];
    assign w_unused_addr = ^bus.mem_a[31:18];
    assign w_io          = (w_addr[17:16] == 2'b11);
    assign w_sel_uart    = (w_addr == c_addr_uart);
    assign w_sel_stop    = (w_addr == c_addr_stop);
    assign w_sel_cnt     = (w_addr[17:2] == c_addr_stop[17:2]);

    logic r_program_stop;

    // Once stopped, the I/O window becomes write-inert
    assign w_io_wr = bus.mem_wr & w_io & ~r_program_stop;
    assign w_io_rd = ~bus.mem_wr & w_io;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_tx_mem [TX_DEPTH];
    logic [c_tx_aw-1:0] r_tx_wp;
    logic [c_tx_aw-1:0] r_tx_rp;
    logic [c_tx_cw-1:0] r_tx_count;
    logic [c_tx_cw-1:0] w_tx_count_nxt;
    logic [c_tx_cw-1:0] w_tx_free_nxt;
    logic               r_io_full;
    logic               r_tx_overflow;
    logic               w_tx_req;
    logic               w_tx_room;
    logic               w_tx_push;
    logic               w_tx_drop;
    logic               w_tx_pop;
    logic [7:0]         w_tx_wdata;

    assign w_tx_req   = w_io_wr & ((w_sel_uart & (bus.mem_dout != 8'h00)) | w_sel_stop);
    // Room is judged on the pre-edge count; a simultaneous pop does not help
    assign w_tx_room  = (r_tx_count != c_tx_full);
    assign w_tx_push  = w_tx_req & w_tx_room;
    assign w_tx_drop  = w_tx_req & ~w_tx_room;
    assign w_tx_pop   = (r_tx_count != '0) & bus.tx_ready;
    assign w_tx_wdata = w_sel_stop ? 8'h00 : bus.mem_dout;

    always_comb begin
        w_tx_count_nxt = r_tx_count;
        if (w_tx_push && !w_tx_pop) begin
            w_tx_count_nxt = r_tx_count + c_tx_cnt_one;
        end else if (w_tx_pop && !w_tx_push) begin
            w_tx_count_nxt = r_tx_count - c_tx_cnt_one;
        end
    end

    assign w_tx_free_nxt = c_tx_full - w_tx_count_nxt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_tx_wp        <= '0;
            r_tx_rp        <= '0;
            r_tx_count     <= '0;
            r_io_full      <= 1'b0;
            r_tx_overflow  <= 1'b0;
            r_program_stop <= 1'b0;
        end else begin
            if (w_tx_push) begin
                r_tx_wp <= r_tx_wp + c_tx_ptr_one;
            end
            if (w_tx_pop) begin
                r_tx_rp <= r_tx_rp + c_tx_ptr_one;
            end
            r_tx_count <= w_tx_count_nxt;
            r_io_full  <= (w_tx_free_nxt <= c_tx_margin);
            if (w_tx_drop) begin
                r_tx_overflow <= 1'b1;
            end
            if (w_io_wr && w_sel_stop) begin
                r_program_stop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wp] <= w_tx_wdata;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_rx_mem [RX_DEPTH];
    logic [c_rx_aw-1:0] r_rx_wp;
    logic [c_rx_aw-1:0] r_rx_rp;
    logic [c_rx_cw-1:0] r_rx_count;
    logic               w_rx_ready;
    logic               w_rx_nonempty;
    logic               w_rx_push;
    logic               w_rx_pop;

    assign w_rx_ready    = (r_rx_count != c_rx_full);
    assign w_rx_nonempty = (r_rx_count != '0);
    assign w_rx_push     = bus.rx_valid & w_rx_ready;
    assign w_rx_pop      = w_io_rd & w_sel_uart & w_rx_nonempty;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wp <= r_rx_wp + c_rx_ptr_one;
            end
            if (w_rx_pop) begin
                r_rx_rp <= r_rx_rp + c_rx_ptr_one;
            end
            if (w_rx_push && !w_rx_pop) begin
                r_rx_count <= r_rx_count + c_rx_cnt_one;
            end else if (w_rx_pop && !w_rx_push) begin
                r_rx_count <= r_rx_count - c_rx_cnt_one;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wp] <= bus.rx_data;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter, snapshot and I/O read data
    // ------------------------------------------------------------------
    logic [31:0] r_cycle;
    logic [31:0] r_snap;
    logic [7:0]  r_io_q;
    logic        r_rd_ram;
    logic [7:0]  w_io_rdata;

    // Byte 0 returns the live counter so it matches what is latched into the snapshot
    always_comb begin
        w_io_rdata = 8'h00;
        if (w_sel_uart) begin
            if (w_rx_nonempty) begin
                w_io_rdata = r_rx_mem[r_rx_rp];
            end
        end else if (w_sel_cnt) begin
            if (w_addr[1:0] == 2'b00) begin
                w_io_rdata = r_cycle[7:0];
            end else begin
                w_io_rdata = r_snap[{w_addr[1:0], 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cycle  <= CYCLE_RESET;
            r_snap   <= 32'h0000_0000;
            r_io_q   <= 8'h00;
            r_rd_ram <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (!bus.mem_wr) begin
                r_rd_ram <= ~w_io;
                r_io_q   <= w_io_rdata;
                if (w_io_rd && w_sel_cnt && (w_addr[1:0] == 2'b00)) begin
                    r_snap <= r_cycle;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM (contents survive reset)
    // ------------------------------------------------------------------
    logic [7:0] r_ram [0:(1 << ADDR_WIDTH) - 1];
    logic [7:0] r_ram_q;

    always_ff @(posedge clk_in) begin
        if (bus.mem_wr && !w_io) begin
            r_ram[w_ram_idx] <= bus.mem_dout;
        end
        if (!bus.mem_wr && !w_io) begin
            r_ram_q <= r_ram[w_ram_idx];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.mem_din        = r_rd_ram ? r_ram_q : r_io_q;
    assign bus.io_buffer_full = r_io_full;
    assign bus.tx_data        = r_tx_mem[r_tx_rp];
    assign bus.tx_valid       = (r_tx_count != '0);
    assign bus.rx_ready       = w_rx_ready;
    assign bus.program_stop   = r_program_stop;
    assign bus.tx_overflow    = r_tx_overflow;

endmodule
`default_nettype wire
